// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stability-qualified debouncer. Produces a clean level
// for a downstream D flip-flop together with single-cycle rise/fall pulses.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic res,
    input  logic din_raw,
    input  logic tick_en,
    output logic dout,
    output logic rise_p,
    output logic fall_p,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        sync1_d = din_raw;
        sync2_d = sync1_q;

        // Abort is tested before completion so a bounce on the final tick cancels.
        case (state_q)
            IDLE_LO: begin
                if (sync2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                end
            end
            IDLE_HI: begin
                if (!sync2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!sync2_q) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (tick_en && (cnt_q == CNT_LAST)) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else if (tick_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (sync2_q) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (tick_en && (cnt_q == CNT_LAST)) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else if (tick_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout   = dout_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign busy   = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule
